icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped instruction cache sitting directly upstream of the pipelined core's IF stage, in place of the single-cycle instruction ROM.
- Serves instr_IF combinationally on a hit, the same timing as the ROM it replaces.
- On a miss, asserts a stall that holds the PC and IF/ID registers, and refills one line word-serially from a slower backing memory over a req/ready handshake.

Parameters:
- LINES, 16, number of cache lines; power of 2, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_IF  in  ADDR_W  fetch byte address from the PC register; bits [1:0] are ignored.
- instr_IF  out  32  fetched instruction; valid when miss_stall=0.
- miss_stall  out  1  1 = hold the PC and IF/ID registers, and the core inserts a bubble.
- flush  in  1  one-cycle pulse that invalidates every line.
- mem_req  out  1  backing-memory word read request.
- mem_addr  out  ADDR_W  word-aligned backing-memory address.
- mem_rdata  in  32  backing-memory read data; valid when mem_ready=1.
- mem_ready  in  1  beat accepted; mem_rdata is valid in the same cycle.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE), IDX = log2(LINES).
  - word = pc[OFF+1:2], index = pc[OFF+IDX+1:OFF+2], tag = pc[ADDR_W-1:OFF+IDX+2].
- Storage: data array LINES x WORDS_PER_LINE x 32, plus a tag array and a valid bit per line, all registers.
- hit = valid[index] && tag_arr[index]==tag, computed combinationally in IDLE.
- Reset (rst=0, asynchronous):
  - state=IDLE, all valid=0, beat counter=0, flush_pend=0.
  - mem_req=0, mem_addr=0.
- FSM, two states:
  - IDLE:
    - miss_stall = !hit.
    - instr_IF = data[index][word] on a hit, 32'h0 (NOP) otherwise.
    - On a miss, latch the refill base {tag,index,OFF+2 zero bits}, beat=0, go to REFILL.
  - REFILL:
    - miss_stall=1, instr_IF=32'h0, mem_req=1, mem_addr = base + 4*beat.
    - Each cycle with mem_ready=1: write mem_rdata to data[idx][beat], beat++.
    - mem_addr and mem_req stay stable while mem_ready=0.
    - On the last beat (beat==WORDS_PER_LINE-1 && mem_ready), in the same edge: write tag_arr and set valid[idx]=1, drop mem_req, return to IDLE.
- Latency:
  - Hit: 0 stall cycles.
  - Miss with mem_ready held high: WORDS_PER_LINE+1 stall cycles (detect cycle plus beats). The fetch hits the cycle after return.
- pc_IF changes during REFILL (e.g. a branch resolved in ID): the refill completes for the latched line, then IDLE looks up the current pc_IF, which may miss again.
- flush:
  - In IDLE: clears all valid bits at the edge; a hit in that same cycle is still delivered.
  - In REFILL: sets flush_pend. When the refill completes, all valid bits are cleared, including the new line, and flush_pend=0.
- A refill always overwrites the indexed line, valid or not; there is no write path from the core.
- Reset asserted mid-refill: the refill is abandoned immediately, mem_req=0, and no partial line becomes valid.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined: adds outputs hit_count and miss_count, 32 bits each, reset to 0.
  - hit_count increments per IDLE cycle with hit=1.
  - miss_count increments per IDLE->REFILL transition.
  - Both wrap at 2^32 and do not count during REFILL.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (icache_pkg):
  - State encoding IDLE=1'b0, REFILL=1'b1.
  - Localparam functions for OFF, IDX and tag width.
  - NOP constant 32'h0.
- One sub-module, icache_refill_fsm: owns the state, beat counter, flush_pend and the mem_* outputs. The top holds the arrays and hit logic.

Test Plan (defaults: index=pc[7:4], tag=pc[31:8]):
1. After reset, pc_IF=0x000 with mem_ready=1 every cycle -> miss_stall=1 for 5 cycles, mem_addr steps 0x0, 0x4, 0x8, 0xC -> next cycle miss_stall=0 and instr_IF equals the memory word at 0x0.
2. pc_IF=0x004, 0x008, 0x00C after fill 1 -> hits, miss_stall=0 each cycle, no mem_req.
3. pc_IF=0x100 (index 0, tag 1) -> conflict refill 0x100-0x10C; then pc_IF=0x000 -> misses again.
4. mem_ready held 0 for 3 cycles on beat 2 -> mem_req=1 and mem_addr=0x008 stable, miss_stall held, refilled line correct.
5. flush pulsed during beat 1 of a refill -> refill completes, then all lines invalid; the same pc misses and refills again.
6. rst pulsed low mid-refill -> mem_req=0 asynchronously; after release, pc 0x000 misses (no partial line valid). With ICACHE_PERF_EN, counters read 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam logic [31:0] NOP = 32'h0;

  function automatic int off_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Byte-offset bits [1:0] sit below the word offset.
  function automatic int tag_bits(input int addr_w, input int lines, input int words_per_line);
    return addr_w - $clog2(lines) - $clog2(words_per_line) - 2;
  endfunction

endpackage

// File: rtl/icache_direct_if.sv
// Backing-memory read channel: word requests from the cache, data/ready from memory.
interface icache_direct_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ready);
  modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ready);
endinterface

// File: rtl/icache_refill_fsm.sv
// Miss/refill sequencer: owns state, beat counter, pending flush and the memory request.
//   state  | meaning
//   IDLE   | lookups served combinationally by the top; a miss latches the line base
//   REFILL | one word per accepted beat is fetched from backing memory
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 base,
  input  logic                              flush,
  icache_direct_if.master                   mem,
  output state_t                            state,
  output logic [off_bits(WORDS_PER_LINE)-1:0] beat,
  output logic                              fill_we,
  output logic                              fill_last,
  output logic                              flush_pend
);

  localparam int OFF = off_bits(WORDS_PER_LINE);
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(WORDS_PER_LINE - 1);

  assign fill_we   = (state == REFILL) && mem.mem_ready;
  assign fill_last = fill_we && (beat == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      beat         <= '0;
      flush_pend   <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= REFILL;
            beat         <= '0;
            flush_pend   <= 1'b0;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= base;
          end
        end
        REFILL: begin
          if (fill_last) begin
            state       <= IDLE;
            beat        <= '0;
            flush_pend  <= 1'b0;
            mem.mem_req <= 1'b0;
          end else begin
            if (flush) flush_pend <= 1'b1;
            if (mem.mem_ready) begin
              beat         <= beat + OFF'(1);
              mem.mem_addr <= mem.mem_addr + ADDR_W'(4);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache in front of the IF stage; hit served combinationally.
// Optional ICACHE_PERF_EN adds hit/miss counters.
module icache_direct
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_IF,
  output logic [31:0]       instr_IF,
  output logic              miss_stall,
  input  logic              flush,
  icache_direct_if.master   mem
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF   = off_bits(WORDS_PER_LINE);
  localparam int IDX   = idx_bits(LINES);
  localparam int TAG_W = tag_bits(ADDR_W, LINES, WORDS_PER_LINE);

  logic [OFF-1:0]   word;
  logic [IDX-1:0]   index;
  logic [TAG_W-1:0] tag;

  logic [31:0]      data_arr [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [LINES-1:0] valid;

  state_t           state;
  logic [OFF-1:0]   beat;
  logic             fill_we, fill_last, flush_pend;
  logic             hit, start;
  logic [IDX-1:0]   fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             unused_bits;

  assign word  = pc_IF[OFF+1:2];
  assign index = pc_IF[OFF+IDX+1:OFF+2];
  assign tag   = pc_IF[ADDR_W-1:OFF+IDX+2];

  // The request address stays inside the latched line, so it carries the fill index and tag.
  assign fill_idx = mem.mem_addr[OFF+IDX+1:OFF+2];
  assign fill_tag = mem.mem_addr[ADDR_W-1:OFF+IDX+2];
  assign unused_bits = ^{pc_IF[1:0], mem.mem_addr[OFF+1:0]};

  assign hit        = (state == IDLE) && valid[index] && (tag_arr[index] == tag);
  assign start      = (state == IDLE) && !hit;
  assign miss_stall = !hit;
  assign instr_IF   = hit ? data_arr[index][word] : NOP;

  icache_refill_fsm #(
    .ADDR_W         (ADDR_W),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill_fsm (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base       ({tag, index, {(OFF + 2){1'b0}}}),
    .flush      (flush),
    .mem        (mem),
    .state      (state),
    .beat       (beat),
    .fill_we    (fill_we),
    .fill_last  (fill_last),
    .flush_pend (flush_pend)
  );

  // A flush seen during the refill also drops the line just written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if ((state == IDLE) && flush) begin
      valid <= '0;
    end else if (fill_last) begin
      if (flush_pend || flush) valid <= '0;
      else                     valid <= valid | (LINES'(1) << fill_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)   data_arr[fill_idx][beat] <= mem.mem_rdata;
    if (fill_last) tag_arr[fill_idx]        <= fill_tag;
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)   hit_count  <= hit_count + 32'd1;
      if (start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct with a combinational backing-memory model.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        ready_drv;
  logic [31:0] instr;
  logic        stall;
  int          errors = 0;
  int          checks = 0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_direct_if #(.ADDR_W(32)) mem_if ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  assign mem_if.mem_rdata = mem_word(mem_if.mem_addr);
  assign mem_if.mem_ready = ready_drv;

  icache_direct #(.LINES(16), .WORDS_PER_LINE(4), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_IF      (pc),
    .instr_IF   (instr),
    .miss_stall (stall),
    .flush      (flush),
    .mem        (mem_if)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the miss-detect cycle with ready held high; ends in the first hit cycle.
  task automatic run_refill(input string tag);
    logic [31:0] base;
    base = {pc[31:4], 4'h0};
    chk({tag, " detect stall"}, 32'(stall), 32'd1);
    chk({tag, " detect req"}, 32'(mem_if.mem_req), 32'd0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk({tag, " beat req"}, 32'(mem_if.mem_req), 32'd1);
      chk({tag, " beat addr"}, mem_if.mem_addr, base + 32'(4 * b));
      chk({tag, " beat stall"}, {stall, instr[30:0]}, 32'h8000_0000);
    end
    step();
    chk({tag, " done stall"}, 32'(stall), 32'd0);
    chk({tag, " done req"}, 32'(mem_if.mem_req), 32'd0);
    chk({tag, " done instr"}, instr, mem_word({pc[31:2], 2'b00}));
  endtask

  task automatic expect_hit(input string tag, input logic [31:0] a);
    pc = a;
    #1;
    chk({tag, " stall"}, 32'(stall), 32'd0);
    chk({tag, " req"}, 32'(mem_if.mem_req), 32'd0);
    chk({tag, " instr"}, instr, mem_word(a));
  endtask

  initial begin
    rst = 1'b0; pc = 32'h0; flush = 1'b0; ready_drv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req", 32'(mem_if.mem_req), 32'd0);
    chk("reset addr", mem_if.mem_addr, 32'h0);
    chk("reset stall", 32'(stall), 32'd1);
    chk("reset instr", instr, 32'h0);
    rst = 1'b1;

    // 1: cold miss at 0x000
    run_refill("fill0");
    // 2: hits in the same line
    expect_hit("hit4", 32'h004);
    step();
    expect_hit("hit8", 32'h008);
    step();
    expect_hit("hitC", 32'h00C);
    step();

    // 3: conflict on index 0
    pc = 32'h100; #1;
    run_refill("fill100");
    expect_hit("hit10C", 32'h10C);
    step();
    pc = 32'h000; #1;
    run_refill("refill0");

    // 4: stalled beat 2
    pc = 32'h200; #1;
    chk("st detect", 32'(stall), 32'd1);
    step(); step(); step();
    chk("st beat2 addr", mem_if.mem_addr, 32'h208);
    ready_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st hold req", 32'(mem_if.mem_req), 32'd1);
      chk("st hold addr", mem_if.mem_addr, 32'h208);
      chk("st hold stall", 32'(stall), 32'd1);
    end
    ready_drv = 1'b1;
    step();
    chk("st beat3 addr", mem_if.mem_addr, 32'h20C);
    step();
    for (int i = 0; i < 4; i++) begin
      expect_hit("st line", 32'h200 + 32'(4 * i));
    end
    step();

    // 5: flush during refill, with another line valid beforehand
    pc = 32'h010; #1;
    run_refill("fill010");
    step();
    pc = 32'h300; #1;
    chk("fl detect", 32'(stall), 32'd1);
    step(); step();
    chk("fl beat1 addr", mem_if.mem_addr, 32'h304);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(); step();
    chk("fl after stall", 32'(stall), 32'd1);
    chk("fl after req", 32'(mem_if.mem_req), 32'd0);
    run_refill("fl refill");
    step();
    pc = 32'h010; #1;
    chk("fl other line gone", 32'(stall), 32'd1);
    run_refill("fl refill010");

    // flush in IDLE: hit still delivered this cycle, line gone next cycle
    flush = 1'b1;
    #1;
    chk("idle flush stall", 32'(stall), 32'd0);
    chk("idle flush instr", instr, mem_word(32'h010));
    step();
    flush = 1'b0;
    #1;
    chk("idle flush after", 32'(stall), 32'd1);
    run_refill("idle flush refill");
    step();

    // 6: reset mid-refill
    pc = 32'h400; #1;
    step(); step();
    chk("rst pre req", 32'(mem_if.mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst async req", 32'(mem_if.mem_req), 32'd0);
    chk("rst async addr", mem_if.mem_addr, 32'h0);
    step();
    rst = 1'b1;
    pc = 32'h000; #1;
    chk("rst post miss0", 32'(stall), 32'd1);
`ifdef ICACHE_PERF_EN
    chk("rst hit_count", hit_count, 32'd0);
    chk("rst miss_count", miss_count, 32'd0);
`endif
    run_refill("rst refill0");
    pc = 32'h010; #1;
    chk("rst post miss010", 32'(stall), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
